// File: rtl/nco_i2c_pkg.sv
// Shared types and constants for the NCO I2C configuration master.
// States, the default slave address, byte-count presets and per-phase quarter counts.
package nco_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h6A;

  localparam int CTRL_ONLY_LEN = 0;
  localparam int DUTY_LEN      = 2;
  localparam int FREQ_LEN      = 8;
  localparam int MAX_LEN       = 8;

  localparam int START_QUARTERS = 2;
  localparam int BIT_QUARTERS   = 4;
  localparam int STOP_QUARTERS  = 3;

  // Lengths above the payload width are treated as a full 8-byte write.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/nco_i2c_config_master_if.sv
// Request-side handshake and I2C bus signals of the NCO configuration master.
interface nco_i2c_config_master_if;

  // req is taken on a clock edge where ready is high; on that edge ready falls
  // and busy rises, and busy stays high until the single-cycle done pulse.
  logic        req;
  logic        ready;
  logic [7:0]  ctrl_byte;
  logic [63:0] payload;
  logic [3:0]  payload_len;
  logic        busy;
  logic        done;
  logic        nack_err;
  logic        scl;
  logic        sda_oe;
  logic        sda_in;

  modport master (
    input  req, ctrl_byte, payload, payload_len, sda_in,
    output ready, busy, done, nack_err, scl, sda_oe
  );

  modport slave (
    output req, ctrl_byte, payload, payload_len, sda_in,
    input  ready, busy, done, nack_err, scl, sda_oe
  );

endinterface

// File: rtl/nco_i2c_config_master_quarter_tick.sv
// SCL quarter-period prescaler: counts 0..CLK_DIV-1 and ticks for one cycle on the last count.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              W    = $clog2(CLK_DIV);
  localparam logic [W-1:0]    LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/nco_i2c_config_master.sv
// Single-master I2C write engine: START, address byte, control byte, 0..8 payload bytes, STOP.
// All bus changes happen on quarter ticks; outputs are registered in the FSM block.
module nco_i2c_config_master
  import nco_i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 10,
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF
) (
  input  logic   clk,
  input  logic   reset,
  nco_i2c_config_master_if.master bus,
  output state_t state
);

  localparam logic [7:0] ADDR_BYTE  = {SLAVE_ADDR, 1'b0};
  localparam logic [1:0] START_LAST = 2'(START_QUARTERS - 1);
  localparam logic [1:0] BIT_LAST   = 2'(BIT_QUARTERS - 1);
  localparam logic [1:0] STOP_LAST  = 2'(STOP_QUARTERS - 1);
  localparam logic [1:0] Q_RISE     = 2'd0;
  localparam logic [1:0] Q_FALL     = 2'd2;

  state_t      state_q;
  logic        tick;
  logic [1:0]  quarter;
  logic [2:0]  bit_idx;
  logic [7:0]  cur_byte;
  logic [7:0]  next_byte;
  logic [63:0] pay_q;
  logic [3:0]  bytes_left;
  logic        nack_flag;
  logic        ready_q, busy_q, done_q, nack_err_q, scl_q, sda_oe_q;
  logic [3:0]  len_c;
  logic [63:0] pay_aligned;

  assign len_c       = clamp_len(bus.payload_len);
  // Left-justify the selected bytes so the next byte to send is always pay_q[63:56].
  assign pay_aligned = bus.payload << {4'd8 - len_c, 3'b000};

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      quarter    <= '0;
      bit_idx    <= '0;
      cur_byte   <= '0;
      next_byte  <= '0;
      pay_q      <= '0;
      bytes_left <= '0;
      nack_flag  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_err_q <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      nack_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          scl_q     <= 1'b1;
          sda_oe_q  <= 1'b0;
          nack_flag <= 1'b0;
          ready_q   <= 1'b1;
          if (bus.req) begin
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            cur_byte   <= ADDR_BYTE;
            next_byte  <= bus.ctrl_byte;
            pay_q      <= pay_aligned;
            bytes_left <= len_c + 4'd1;
            quarter    <= '0;
            state_q    <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (quarter == START_LAST) begin
              quarter  <= '0;
              scl_q    <= 1'b0;
              bit_idx  <= 3'd7;
              sda_oe_q <= ~cur_byte[7];
              state_q  <= ST_BIT;
            end else begin
              quarter  <= quarter + 2'd1;
              sda_oe_q <= 1'b1;
            end
          end
        end

        ST_BIT: begin
          if (tick) begin
            if (quarter == BIT_LAST) begin
              quarter <= '0;
              if (bit_idx == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_ACK;
              end else begin
                bit_idx  <= bit_idx - 3'd1;
                sda_oe_q <= ~cur_byte[bit_idx - 3'd1];
              end
            end else begin
              quarter <= quarter + 2'd1;
              if (quarter == Q_RISE) scl_q <= 1'b1;
              if (quarter == Q_FALL) scl_q <= 1'b0;
            end
          end
        end

        ST_ACK: begin
          if (tick) begin
            if (quarter == BIT_LAST) begin
              quarter <= '0;
              if (nack_flag || bytes_left == 4'd0) begin
                sda_oe_q <= 1'b1;
                state_q  <= ST_STOP;
              end else begin
                cur_byte   <= next_byte;
                next_byte  <= pay_q[63:56];
                pay_q      <= {pay_q[55:0], 8'h00};
                bytes_left <= bytes_left - 4'd1;
                bit_idx    <= 3'd7;
                sda_oe_q   <= ~next_byte[7];
                state_q    <= ST_BIT;
              end
            end else begin
              quarter <= quarter + 2'd1;
              if (quarter == Q_RISE) scl_q <= 1'b1;
              // SCL has been high for two quarters here; the slave's answer is settled.
              if (quarter == Q_FALL) begin
                scl_q     <= 1'b0;
                nack_flag <= bus.sda_in;
              end
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (quarter == STOP_LAST) begin
              quarter    <= '0;
              done_q     <= 1'b1;
              nack_err_q <= nack_flag;
              busy_q     <= 1'b0;
              state_q    <= ST_DONE;
            end else begin
              quarter <= quarter + 2'd1;
              if (quarter == 2'd0) scl_q    <= 1'b1;
              if (quarter == 2'd1) sda_oe_q <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          ready_q   <= 1'b1;
          nack_flag <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.nack_err = nack_err_q;
  assign bus.scl      = scl_q;
  assign bus.sda_oe   = sda_oe_q;
  assign state        = state_q;

endmodule
